// File: rtl/cmd_pkg.sv
// cmd_pkg: opcodes, packet geometry and serializer states shared by the command packer and extractor
package cmd_pkg;
  localparam logic [1:0] OP_CREATE   = 2'd0;
  localparam logic [1:0] OP_ISSUE    = 2'd1;
  localparam logic [1:0] OP_TRANSFER = 2'd2;
  localparam logic [1:0] OP_REFER    = 2'd3;
  localparam int PKT_BYTES  = 13;
  localparam int OVERSAMPLE = 16;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
endpackage

// File: rtl/cmd_packer_if.sv
// cmd_packer_if: command request and serial/status signals between a command unit and the packer
interface cmd_packer_if #(
  parameter int PAYLOAD_BYTES = 12
);
  logic                       start;
  logic [1:0]                 opcode;
  logic [8*PAYLOAD_BYTES-1:0] payload;
  logic                       dout;
  logic                       busy;
  logic                       done;
  modport master (output start, opcode, payload, input dout, busy, done);
  modport slave  (input start, opcode, payload, output dout, busy, done);
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer for one byte; a load on the final stop tick chains the next byte gap-free
module uart_tx_byte import cmd_pkg::*; #(
  parameter int TICKS = OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_dout,
  output logic       o_byte_done
);
  tx_state_e  r_state;
  logic [3:0] r_tick;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic       r_dout;
  logic       w_end;
  assign w_end       = i_tick && r_state != TX_IDLE && r_tick == 4'(TICKS - 1);
  assign o_byte_done = w_end && r_state == TX_STOP;
  assign o_dout      = r_dout;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TX_IDLE;
      r_tick  <= 4'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_dout  <= 1'b1;
    end else begin
      r_tick <= w_end ? 4'd0 : r_tick + 4'(i_tick && r_state != TX_IDLE);
      if (i_load && (r_state == TX_IDLE || o_byte_done)) begin
        r_state <= TX_START;
        r_shift <= i_data;
        r_bit   <= 3'd0;
        r_dout  <= 1'b0;
      end else if (w_end) begin
        case (r_state)
          TX_START: begin
            r_state <= TX_DATA;
            r_dout  <= r_shift[0];
          end
          TX_DATA: begin
            r_bit   <= r_bit + 3'd1;
            r_shift <= r_shift >> 1;
            r_state <= r_bit == 3'd7 ? TX_STOP : TX_DATA;
            r_dout  <= r_bit == 3'd7 ? 1'b1 : r_shift[1];
          end
          default: r_state <= TX_IDLE;
        endcase
      end
    end
  end
endmodule

// File: rtl/cmd_packer.sv
// cmd_packer: frames {payload, opcode} as a 13-byte packet and sends it as back-to-back 8N1 bytes
module cmd_packer #(
  parameter int PAYLOAD_BYTES = cmd_pkg::PKT_BYTES - 1,
  parameter int OVERSAMPLE    = cmd_pkg::OVERSAMPLE
) (
  input logic         clk,
  input logic         rst,
  input logic         tick_in,
  cmd_packer_if.slave cmd
);
  logic                       r_busy;
  logic                       r_done;
  logic [3:0]                 r_idx;
  logic [8*PAYLOAD_BYTES-1:0] r_buf;
  logic                       w_accept;
  logic                       w_last;
  logic                       w_load;
  logic                       w_byte_done;
  logic [7:0]                 w_data;
  // r_done blocks acceptance so a start coinciding with done waits one cycle
  assign w_accept = cmd.start && !r_busy && !r_done;
  assign w_last   = r_idx == 4'(PAYLOAD_BYTES);
  assign w_load   = w_accept || (w_byte_done && !w_last);
  assign w_data   = r_busy ? r_buf[7:0] : {6'b0, cmd.opcode};
  assign cmd.busy = r_busy;
  assign cmd.done = r_done;
  uart_tx_byte #(.TICKS(OVERSAMPLE)) u_tx (
    .clk         (clk),
    .rst         (rst),
    .i_tick      (tick_in),
    .i_load      (w_load),
    .i_data      (w_data),
    .o_dout      (cmd.dout),
    .o_byte_done (w_byte_done)
  );
  // opcode byte goes straight to the serializer; the buffer holds only payload, shifted down per byte
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_idx  <= 4'd0;
      r_buf  <= '0;
    end else begin
      r_done <= w_byte_done && w_last;
      if (w_accept) begin
        r_busy <= 1'b1;
        r_idx  <= 4'd0;
        r_buf  <= cmd.payload;
      end else if (w_byte_done) begin
        r_busy <= !w_last;
        r_idx  <= w_last ? r_idx : r_idx + 4'd1;
        r_buf  <= r_buf >> 8;
      end
    end
  end
endmodule

// File: tb/tb_cmd_packer.sv
// tb_cmd_packer: drives random packets and checks the serial line cycle by cycle against a tick-count frame model
module tb_cmd_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_in = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  int tick_div = 4;
  cmd_packer_if #(.PAYLOAD_BYTES(12)) cmd ();
  cmd_packer #(.PAYLOAD_BYTES(12), .OVERSAMPLE(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick_in (tick_in),
    .cmd     (cmd)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // line level after c ticks since acceptance: 130 bit times of 16 ticks, 10 bits per byte
  function automatic logic line_bit(input int c, input logic [103:0] f);
    int b;
    int pos;
    b = c / 16;
    pos = b % 10;
    if (b >= 130 || pos == 9) return 1'b1;
    if (pos == 0) return 1'b0;
    return f[(b / 10) * 8 + pos - 1];
  endfunction

  function automatic logic [95:0] rand_pl();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic run_packet(input logic [1:0] op, input logic [95:0] pl, input bit hold,
                            input bit poke, input int stall_at, input int abort_at);
    logic [103:0] f;
    logic         cap [130];
    logic [9:0]   o;
    int cnt, cyc, mism, done_at, stalled;
    bit poked;
    f = {pl, 6'b0, op};
    cnt = 0; cyc = 0; mism = 0; done_at = -1; stalled = 0; poked = 0;
    @(negedge clk);
    check("idle_busy", int'(cmd.busy), 0);
    check("idle_done", int'(cmd.done), 0);
    check("idle_dout", int'(cmd.dout), 1);
    cmd.start = 1'b1;
    cmd.opcode = op;
    cmd.payload = pl;
    tick_in = 1'($urandom_range(0, 1));
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && !hold) begin
        cmd.start = 1'b0;
        cmd.opcode = 2'($urandom);
        cmd.payload = rand_pl();
      end
      mism += int'(cmd.dout !== line_bit(cnt, f)) + int'(cmd.busy !== (cnt < 2080))
            + int'(cmd.done !== (cnt == 2080));
      if (cnt % 16 == 8 && cnt < 2080) cap[cnt / 16] = cmd.dout;
      if (cmd.done === 1'b1 && done_at < 0) done_at = cnt;
      if (cnt == 2080) break;
      if (cyc > 30000) begin
        check("timeout", cnt, 2080);
        break;
      end
      if (cnt == abort_at) begin
        rst = 1'b1;
        tick_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_trace", mism, 0);
        check("abort_dout", int'(cmd.dout), 1);
        check("abort_busy", int'(cmd.busy), 0);
        check("abort_done", int'(cmd.done), 0);
        rst = 1'b0;
        return;
      end
      if (poke) begin
        if (cnt >= 300 && !poked) begin
          cmd.start = 1'b1;
          cmd.opcode = 2'd3;
          cmd.payload = rand_pl();
          poked = 1;
        end else if (poked) cmd.start = 1'b0;
      end
      if (cnt == stall_at && stalled < 500) begin
        tick_in = 1'b0;
        stalled++;
      end else tick_in = tick_div > 0 ? cyc % tick_div == 0 : 1'($urandom_range(0, 1));
      @(posedge clk);
      if (tick_in) cnt++;
    end
    check("trace", mism, 0);
    check("done_tick", done_at, 2080);
    for (int k = 0; k < 13; k++) begin
      for (int i = 0; i < 10; i++) o[i] = cap[k * 10 + i];
      check($sformatf("byte%0d", k), int'(o), int'({1'b1, f[k * 8 +: 8], 1'b0}));
    end
  endtask

  initial begin
    logic [95:0] pl;
    int viol;
    cmd.start = 1'b0;
    cmd.opcode = 2'd0;
    cmd.payload = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_dout", int'(cmd.dout), 1);
    check("rst_busy", int'(cmd.busy), 0);
    check("rst_done", int'(cmd.done), 0);
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      tick_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      viol += int'(cmd.dout !== 1'b1) + int'(cmd.busy !== 1'b0) + int'(cmd.done !== 1'b0);
    end
    check("idle_line", viol, 0);
    for (int k = 0; k < 12; k++) pl[8 * k +: 8] = 8'(k + 1);
    tick_div = 4;
    run_packet(2'd2, pl, 0, 0, -1, -1);
    run_packet(2'd1, rand_pl(), 0, 1, -1, -1);
    tick_div = 0;
    run_packet(2'($urandom), rand_pl(), 1, 0, -1, -1);
    run_packet(2'($urandom), rand_pl(), 1, 0, -1, -1);
    run_packet(2'($urandom), rand_pl(), 0, 0, -1, -1);
    run_packet(2'($urandom), rand_pl(), 0, 0, -1, 870);
    run_packet(2'd0, rand_pl(), 0, 0, -1, -1);
    run_packet(2'($urandom), rand_pl(), 0, 0, 1000, -1);
    @(negedge clk);
    check("end_done", int'(cmd.done), 0);
    check("end_busy", int'(cmd.busy), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cmd_packer.md
# cmd_packer

Transmit-side counterpart of the command extractor. Accepts one command (2-bit opcode plus fixed-length payload) from a command unit, frames it as a 13-byte packet, and shifts the packet out as 8N1 UART serial on `dout`. Timing is driven by the same oversampling `tick_in` enable used by the receive path. It sits between the create/issue/transfer/refer units and the board TX pin.

## Interface
- `PAYLOAD_BYTES`, 12: payload bytes per packet; packet length is `PAYLOAD_BYTES+1`.
- `OVERSAMPLE`, 16: `tick_in` pulses per serial bit.
- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `tick_in`  in  1: baud enable, one-`clk` pulse, `OVERSAMPLE` pulses per bit.
- `start`  in  1: request; sampled only in IDLE.
- `opcode`  in  2: command code; 0 create, 1 issue, 2 transfer, 3 refer.
- `payload`  in  8*PAYLOAD_BYTES: payload; byte k is `payload[8k+7:8k]`, sent after the opcode in ascending k.
- `dout`  out  1: serial line; idles high.
- `busy`  out  1: high from the cycle after acceptance until `done`.
- `done`  out  1: one-cycle pulse at packet completion.

## Operation
- Reset values: `dout`=1, `busy`=0, `done`=0, state IDLE, all counters 0.
- Acceptance happens when `start`=1 in IDLE. `{payload, 6'b0, opcode}` is latched into the packet buffer, byte 0 = `{6'b0, opcode}`. `start` is ignored while `busy`.
- States:
  - IDLE: on acceptance, go to START with byte index 0.
  - START: `dout`=0 for one bit time, then go to DATA.
  - DATA: 8 bits, LSB first, one bit time each; after bit 7, go to STOP.
  - STOP: `dout`=1 for one bit time. If byte index < `PAYLOAD_BYTES`, increment the index and go to START (no inter-byte gap). Otherwise pulse `done`, clear `busy`, and go to IDLE.
- Bit time: a 4-bit tick counter counts `tick_in` pulses. The bit ends on the `OVERSAMPLE`-th pulse; the counter wraps to 0 at that point.
- Bit counter is 3 bits (0..7). Byte index is 4 bits (0..12); no wrap.
- Payload inputs may change after acceptance without effect.
- Reset asserted mid-packet aborts the packet immediately, with no `done` pulse. `dout` returns high on the next cycle and the line is left in a truncated frame.
- `start` in the same cycle as `done`: not accepted, because the FSM is not yet in IDLE. It is accepted on the following cycle if still high.

## Timing
- Acceptance at cycle N: `busy`=1 and `dout`=0 at N+1.
- The bit period begins at N+1 and lasts exactly `OVERSAMPLE` `tick_in` pulses.
- `dout` changes only on the cycle after the terminating `tick_in` of a bit.
- Byte duration is 10 bits = 160 ticks. Packet duration is 13×160 = 2080 ticks.
- `done` is asserted the cycle after the 2080th tick. `busy` falls in that same cycle.
- Earliest next acceptance is the cycle after `done`.
- `tick_in` absent: the FSM holds state indefinitely with no timeout.

## Structure
- Shared package `cmd_pkg`:
  - opcode constants `OP_CREATE`=0, `OP_ISSUE`=1, `OP_TRANSFER`=2, `OP_REFER`=3
  - `PKT_BYTES`=13
  - `OVERSAMPLE`=16
  - the same constants are used by the extractor.
- One sub-module, `uart_tx_byte`: a single-byte 8N1 serializer with a `load`/`byte_done` handshake.
- `cmd_packer` owns the packet buffer, the byte index, and `busy`/`done`.

## Test plan
- Reset: `rst` held 3 cycles, then released → `dout`=1, `busy`=0, `done`=0; the line stays high with no `start`.
- Single packet: opcode=2, `payload`=0x0C0B...0201 (byte k = k+1), `tick_in` every 4 clks.
  - Serial capture gives 13 bytes: 0x02, 0x01..0x0C, each with start=0 and stop=1.
  - `done` is asserted after exactly 2080 ticks.
  - There is no idle gap between bytes.
- Busy rejection: second `start` with opcode=3 while `busy` → ignored; the captured packet is unchanged; exactly one `done`.
- Back-to-back: `start` held high continuously.
  - Second acceptance occurs the cycle after `done`.
  - Second packet's first start bit begins at that acceptance + 1.
- Mid-packet reset: `rst` during byte 5, bit 3.
  - Next cycle: `dout`=1, `busy`=0, no `done`.
  - A new `start` with opcode=0 produces a clean full packet beginning with 0x00.
- Tick stall: `tick_in` held low for 500 clks mid-bit → `dout` is stable throughout; the bit completes after the remaining ticks and the total tick count is still 2080.
